// File: rtl/acc_ctrl_pkg.sv
// Shared definitions for the accumulator bus arbiter: FSM encoding and
// bank operation codes.
package acc_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_XFER  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Bank operation strobe values
  localparam logic RD = 1'b1;
  localparam logic WR = 1'b0;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin selector. last_gnt is the index of the
// requester granted most recently; on a tie the other one wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic [1:0] winner
);

  // Pure combinational pick; a lone requester always wins
  always_comb begin
    winner = 2'b00;
    case (req)
      2'b01:   winner = 2'b01;
      2'b10:   winner = 2'b10;
      2'b11:   winner = last_gnt ? 2'b01 : 2'b10;
      default: winner = 2'b00;
    endcase
  end

endmodule

// File: rtl/acc_bus_arbiter.sv
// Arbitrates two requesters onto a shared bit-addressed bank. Each access
// runs IDLE -> SETUP -> XFER -> DONE using operands latched in IDLE, so
// requester inputs may change freely once the access has started.
//
// Handshake: a requester raises req[i] with its op/mask/data stable and
// holds it until done[i] pulses for one cycle; gnt[i] is high from SETUP
// through DONE. rdata is valid while done is high and holds until the next
// read completes.
module acc_bus_arbiter
  import acc_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [1:0]       req,
  input  logic [1:0]       req_rw,
  input  logic [WIDTH-1:0] req_mask0,
  input  logic [WIDTH-1:0] req_mask1,
  input  logic [WIDTH-1:0] req_wdata0,
  input  logic [WIDTH-1:0] req_wdata1,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic [WIDTH-1:0] rdata,
  output logic             mem_rw,
  output logic [WIDTH-1:0] mem_bit_add,
  inout  wire  [WIDTH-1:0] mem_data,
  output logic [1:0]       dbg_state,
  output logic             dbg_oe
);

  state_t           state_q, state_d;
  logic             win_q;      // index of the requester being served
  logic             last_q;     // index of the requester served last
  logic             rw_q;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] wdata_q;
  logic [WIDTH-1:0] rdata_q;
  logic             oe_q, oe_d;
  logic             load;

  logic [1:0]       sel_win;
  logic             sel_idx;
  logic             sel_rw;
  logic [WIDTH-1:0] sel_mask;
  logic [WIDTH-1:0] sel_wdata;

  rr_arb2 u_rr_arb2 (
    .req      (req),
    .last_gnt (last_q),
    .winner   (sel_win)
  );

  assign sel_idx   = sel_win[1];
  assign sel_rw    = req_rw[sel_idx];
  assign sel_mask  = sel_idx ? req_mask1  : req_mask0;
  assign sel_wdata = sel_idx ? req_wdata1 : req_wdata0;

  // Next-state logic; the bus enable is precomputed so it can be registered
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    oe_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sel_win != 2'b00) begin
          state_d = ST_SETUP;
          load    = 1'b1;
          oe_d    = (sel_rw == WR);
        end
      end
      ST_SETUP: begin
        state_d = ST_XFER;
        oe_d    = (rw_q == WR);
      end
      ST_XFER: state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, latched operands, read capture and round-robin pointer
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      win_q   <= 1'b0;
      last_q  <= 1'b1;
      rw_q    <= RD;
      mask_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      oe_q    <= oe_d;
      if (load) begin
        win_q   <= sel_idx;
        rw_q    <= sel_rw;
        mask_q  <= sel_mask;
        wdata_q <= sel_wdata;
      end
      if (state_q == ST_XFER && rw_q == RD) begin
        rdata_q <= mem_data & mask_q;
      end
      if (state_q == ST_DONE) begin
        last_q <= win_q;
      end
    end
  end

  // Bank strobes are only live in SETUP/XFER; IDLE and DONE park the bank
  always_comb begin
    gnt         = 2'b00;
    done        = 2'b00;
    mem_rw      = RD;
    mem_bit_add = '0;
    if (state_q != ST_IDLE) begin
      gnt = win_q ? 2'b10 : 2'b01;
    end
    if (state_q == ST_DONE) begin
      done = win_q ? 2'b10 : 2'b01;
    end
    if (state_q == ST_SETUP || state_q == ST_XFER) begin
      mem_rw      = rw_q;
      mem_bit_add = mask_q;
    end
  end

  assign mem_data  = oe_q ? wdata_q : {WIDTH{1'bz}};
  assign rdata     = rdata_q;
  assign dbg_state = state_q;
  assign dbg_oe    = oe_q;

endmodule

// File: tb/tb_acc_bus_arbiter.sv
// Directed bench for acc_bus_arbiter: a small bit-addressed bank model sits
// on mem_data, stimulus tasks push expected completions into a queue, and a
// monitor pops and compares them whenever done pulses.
module tb_acc_bus_arbiter;
  import acc_ctrl_pkg::*;

  localparam int W  = 8;
  localparam int EW = 11; // {done[1:0], is_read, rdata[7:0]}

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic [1:0]   req = 2'b00;
  logic [1:0]   req_rw = 2'b00;
  logic [W-1:0] req_mask0 = '0, req_mask1 = '0;
  logic [W-1:0] req_wdata0 = '0, req_wdata1 = '0;
  logic [1:0]   gnt, done, dbg_state;
  logic [W-1:0] rdata, mem_bit_add;
  logic         mem_rw, dbg_oe;
  wire  [W-1:0] mem_data;

  acc_bus_arbiter #(.WIDTH(W)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req         (req),
    .req_rw      (req_rw),
    .req_mask0   (req_mask0),
    .req_mask1   (req_mask1),
    .req_wdata0  (req_wdata0),
    .req_wdata1  (req_wdata1),
    .gnt         (gnt),
    .done        (done),
    .rdata       (rdata),
    .mem_rw      (mem_rw),
    .mem_bit_add (mem_bit_add),
    .mem_data    (mem_data),
    .dbg_state   (dbg_state),
    .dbg_oe      (dbg_oe)
  );

  // ---------------- bank model ----------------
  logic [W-1:0] bank = 8'h00;
  logic         bank_oe;
  assign bank_oe  = mem_rw && (mem_bit_add != '0);
  assign mem_data = bank_oe ? bank : {W{1'bz}};
  always @(posedge clock) begin
    if (!mem_rw) bank <= (bank & ~mem_bit_add) | (mem_data & mem_bit_add);
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [EW-1:0] exp_q[$];
  bit mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req_v, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clock) begin : monitor
    logic [EW-1:0] e;
    if (mon_en && done != 2'b00) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=%b required=none at %0t", done, $time);
      end else begin
        e = exp_q.pop_front();
        check("mon_done", {30'd0, done}, {30'd0, e[10:9]});
        if (e[8]) check("mon_rdata", {24'd0, rdata}, {24'd0, e[7:0]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk_active(input string ph, input logic [1:0] st, input logic [1:0] oh,
                            input logic rw, input logic [W-1:0] mask, input logic [W-1:0] wd);
    check({ph, "_state"}, {30'd0, dbg_state}, {30'd0, st});
    check({ph, "_gnt"}, {30'd0, gnt}, {30'd0, oh});
    check({ph, "_mem_rw"}, {31'd0, mem_rw}, {31'd0, rw});
    check({ph, "_bit_add"}, {24'd0, mem_bit_add}, {24'd0, mask});
    check({ph, "_oe"}, {31'd0, dbg_oe}, {31'd0, ~rw});
    if (rw == WR) check({ph, "_mem_data"}, {24'd0, mem_data}, {24'd0, wd});
  endtask

  task automatic chk_parked(input string ph);
    check({ph, "_bit_add"}, {24'd0, mem_bit_add}, 32'd0);
    check({ph, "_mem_rw"}, {31'd0, mem_rw}, 32'd1);
    check({ph, "_oe"}, {31'd0, dbg_oe}, 32'd0);
  endtask

  // One access from requester id; mid_change drops req and zeroes wdata in SETUP
  task automatic do_op(input int id, input logic rw, input logic [W-1:0] mask,
                       input logic [W-1:0] wd, input logic [W-1:0] exp_rd, input bit mid_change);
    logic [1:0] oh;
    oh = (id == 1) ? 2'b10 : 2'b01;
    @(posedge clock); #1;
    req[id] = 1'b1;
    req_rw[id] = rw;
    if (id == 0) begin req_mask0 = mask; req_wdata0 = wd; end
    else         begin req_mask1 = mask; req_wdata1 = wd; end
    exp_q.push_back({oh, rw, exp_rd});
    @(posedge clock);                       // edge N: sampled in IDLE
    @(negedge clock);
    chk_active("setup", ST_SETUP, oh, rw, mask, wd);
    if (mid_change) begin
      req[id] = 1'b0;
      if (id == 0) req_wdata0 = 8'h00; else req_wdata1 = 8'h00;
    end
    @(negedge clock);
    chk_active("xfer", ST_XFER, oh, rw, mask, wd);
    @(negedge clock);                       // sampled at edge N+3
    check("latency_done", {30'd0, done}, {30'd0, oh});
    check("done_state", {30'd0, dbg_state}, {30'd0, ST_DONE});
    chk_parked("done");
    req[id] = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (2) @(posedge clock);
    @(negedge clock);
    mon_en = 1'b1;
    check("rst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    check("rst_gnt", {30'd0, gnt}, 32'd0);
    check("rst_done", {30'd0, done}, 32'd0);
    check("rst_rdata", {24'd0, rdata}, 32'd0);
    chk_parked("rst");
    reset_n = 1'b1;

    do_op(0, WR, 8'hFF, 8'hA5, 8'h00, 1'b0);   // bank <- A5
    do_op(1, RD, 8'h0F, 8'h00, 8'h05, 1'b0);   // masked read-back
    repeat (3) @(negedge clock);
    check("rdata_held", {24'd0, rdata}, 32'h05);
    check("idle_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    do_op(0, RD, 8'h00, 8'h00, 8'h00, 1'b0);   // zero mask still completes
    do_op(1, WR, 8'hFF, 8'h00, 8'h00, 1'b0);   // bank <- 00
    do_op(0, WR, 8'hFF, 8'hA5, 8'h00, 1'b1);   // mid-op change, A5 must land
    do_op(1, RD, 8'hFF, 8'h00, 8'hA5, 1'b0);

    // Reset during XFER of a write aborts with no done
    @(posedge clock); #1;
    req = 2'b01; req_rw = 2'b00; req_mask0 = 8'hFF; req_wdata0 = 8'h5A;
    @(posedge clock);
    @(negedge clock);
    check("abort_setup", {30'd0, dbg_state}, {30'd0, ST_SETUP});
    @(negedge clock);
    check("abort_xfer", {30'd0, dbg_state}, {30'd0, ST_XFER});
    reset_n = 1'b0;
    @(negedge clock);
    check("abort_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    check("abort_gnt", {30'd0, gnt}, 32'd0);
    check("abort_done", {30'd0, done}, 32'd0);
    chk_parked("abort");
    req = 2'b00;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    check("abort_no_restart", {30'd0, dbg_state}, {30'd0, ST_IDLE});

    do_op(0, WR, 8'hFF, 8'h3C, 8'h00, 1'b0);   // bank <- 3C

    // Contention: both held from reset, grants must alternate starting at 0
    @(negedge clock);
    reset_n = 1'b0;
    req = 2'b11; req_rw = 2'b11; req_mask0 = 8'h0F; req_mask1 = 8'hF0;
    exp_q.push_back({2'b01, 1'b1, 8'h0C});
    exp_q.push_back({2'b10, 1'b1, 8'h30});
    exp_q.push_back({2'b01, 1'b1, 8'h0C});
    exp_q.push_back({2'b10, 1'b1, 8'h30});
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clock);
      @(negedge clock);
      check("rr_gnt", {30'd0, gnt}, (k % 2 == 0) ? 32'd1 : 32'd2);
      if (k == 3) req = 2'b00;
      repeat (3) @(posedge clock);
    end

    repeat (5) @(negedge clock);
    check("queue_drained", exp_q.size(), 32'd0);
    check("final_idle", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
